// File: rtl/perf_monitor_unit_pkg.sv
// Shared definitions for the performance monitor: register map, CTRL/SEL bit positions,
// the per-counter select register layout and the decoded register kinds.
package perf_monitor_unit_pkg;

  // Global registers, as offsets from the window base
  localparam logic [31:0] PMU_CTRL_OFS     = 32'h000;
  localparam logic [31:0] PMU_OVF_STAT_OFS = 32'h004;
  localparam logic [31:0] PMU_OVF_MASK_OFS = 32'h008;

  // Per-counter block: base + stride*i, then SEL/LO/HI inside the block
  localparam logic [31:0] PMU_CNT_BASE_OFS = 32'h100;
  localparam logic [31:0] PMU_CNT_STRIDE   = 32'd16;
  localparam logic [31:0] PMU_SEL_OFS      = 32'h0;
  localparam logic [31:0] PMU_LO_OFS       = 32'h4;
  localparam logic [31:0] PMU_HI_OFS       = 32'h8;

  // CTRL bits
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  // SEL enable bit in the bus word; event index sits in [7:0]
  localparam int PMU_SEL_EN_BIT = 31;

  // Counter index width: enough for 32 counters
  localparam int PMU_CIDX_W = 5;

  typedef struct packed {
    logic       en;
    logic [7:0] evsel;
  } pmu_sel_t;

  // Decoded target of a bus access; holes inside the window decode as REG_NONE
  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_OVF_STAT,
    REG_OVF_MASK,
    REG_SEL,
    REG_LO,
    REG_HI
  } pmu_reg_e;

  // Bus view of a SEL register: unused bits read as zero
  function automatic logic [31:0] sel_to_word(input pmu_sel_t s);
    logic [31:0] w;
    w                 = '0;
    w[PMU_SEL_EN_BIT] = s.en;
    w[7:0]            = s.evsel;
    return w;
  endfunction

endpackage

// File: rtl/perf_monitor_unit_counter.sv
// One programmable event counter: SEL register, counter value and the hi_hold
// snapshot used for coherent LO-then-HI reads.
module pmu_counter
  import perf_monitor_unit_pkg::*;
#(
  parameter int NUM_EVENTS    = 16,
  parameter int COUNTER_WIDTH = 48
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_EVENTS-1:0]    i_events,
  input  logic                     i_global_en,
  input  logic                     i_clear,
  input  logic                     i_load_sel,
  input  logic                     i_load_lo,
  input  logic                     i_load_hi,
  input  logic                     i_latch_hi,
  input  logic [31:0]              i_wdata,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output pmu_sel_t                 o_sel,
  output logic [31:0]              o_hi_hold,
  output logic                     o_wrap
);

  logic [COUNTER_WIDTH-1:0] r_count;
  pmu_sel_t                 r_sel;
  logic [31:0]              r_hi_hold;

  logic [255:0] w_ev_pad;
  logic [63:0]  w_cnt64;
  logic         w_inc;

  // Zero-padding to the full 8-bit index space makes any index >= NUM_EVENTS read 0
  assign w_ev_pad = 256'(i_events);
  assign w_cnt64  = 64'(r_count);
  assign w_inc    = i_global_en & r_sel.en & w_ev_pad[r_sel.evsel];

  // A wrap only counts when the increment actually lands (clear and loads take priority)
  assign o_wrap    = w_inc & (&r_count) & ~i_clear & ~i_load_lo & ~i_load_hi;
  assign o_count   = r_count;
  assign o_sel     = r_sel;
  assign o_hi_hold = r_hi_hold;

  // Counter value: clear-all, then software load, then increment
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load_lo) begin
      r_count <= COUNTER_WIDTH'({w_cnt64[63:32], i_wdata});
    end else if (i_load_hi) begin
      // Truncation drops HI bits beyond the counter; with a 32-bit counter HI is a no-op
      r_count <= COUNTER_WIDTH'({i_wdata, w_cnt64[31:0]});
    end else if (w_inc) begin
      r_count <= r_count + COUNTER_WIDTH'(1);
    end
  end

  // SEL register and upper-word snapshot taken when LO is read
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sel     <= '0;
      r_hi_hold <= '0;
    end else begin
      if (i_load_sel) begin
        r_sel.en    <= i_wdata[PMU_SEL_EN_BIT];
        r_sel.evsel <= i_wdata[7:0];
      end
      if (i_latch_hi) r_hi_hold <= w_cnt64[63:32];
    end
  end

endmodule

// File: rtl/perf_monitor_unit.sv
// Performance monitor: NUM_COUNTERS event counters behind a memory-mapped register
// window, with overflow status/mask and a registered 1-cycle read port.
module perf_monitor_unit
  import perf_monitor_unit_pkg::*;
#(
  parameter int          NUM_COUNTERS  = 8,
  parameter int          NUM_EVENTS    = 16,
  parameter int          COUNTER_WIDTH = 48,
  parameter logic [31:0] BASE_ADDRESS  = 32'hffff1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_EVENTS-1:0] perf_events,
  input  logic                  io_write_en,
  input  logic                  io_read_en,
  input  logic [31:0]           io_address,
  input  logic [31:0]           io_write_data,
  output logic [31:0]           pmu_read_data,
  output logic                  pmu_read_hit,
  output logic                  overflow_irq
);

  localparam logic [31:0] WIN_END =
    PMU_CNT_BASE_OFS + 32'(NUM_COUNTERS) * PMU_CNT_STRIDE;

  logic                    r_ctrl_en;
  logic [NUM_COUNTERS-1:0] r_ovf_stat;
  logic [NUM_COUNTERS-1:0] r_ovf_mask;
  logic [31:0]             r_rdata;
  logic                    r_rhit;

  logic [31:0]             w_off;
  logic                    w_in_win;
  pmu_reg_e                w_reg;
  logic [PMU_CIDX_W-1:0]   w_cidx;
  logic                    w_wr;
  logic                    w_clear_all;
  logic [NUM_COUNTERS-1:0] w_ovf_w1c;
  logic [31:0]             w_rdata;

  logic [NUM_COUNTERS-1:0][COUNTER_WIDTH-1:0] w_count;
  pmu_sel_t [NUM_COUNTERS-1:0]                w_sel;
  logic [NUM_COUNTERS-1:0][31:0]              w_hi_hold;
  logic [NUM_COUNTERS-1:0]                    w_wrap;

  // Address decode: window check, register kind and counter index
  always_comb begin
    w_off    = io_address - BASE_ADDRESS;
    w_in_win = (w_off < WIN_END);
    w_cidx   = PMU_CIDX_W'((w_off - PMU_CNT_BASE_OFS) >> 4);
    w_reg    = REG_NONE;
    if (w_in_win) begin
      if (w_off < PMU_CNT_BASE_OFS) begin
        if (w_off == PMU_CTRL_OFS)          w_reg = REG_CTRL;
        else if (w_off == PMU_OVF_STAT_OFS) w_reg = REG_OVF_STAT;
        else if (w_off == PMU_OVF_MASK_OFS) w_reg = REG_OVF_MASK;
      end else begin
        // The counter base is 16-byte aligned, so the low nibble locates SEL/LO/HI
        if (w_off[3:0] == PMU_SEL_OFS[3:0])     w_reg = REG_SEL;
        else if (w_off[3:0] == PMU_LO_OFS[3:0]) w_reg = REG_LO;
        else if (w_off[3:0] == PMU_HI_OFS[3:0]) w_reg = REG_HI;
      end
    end
  end

  assign w_wr        = io_write_en & w_in_win;
  assign w_clear_all = w_wr & (w_reg == REG_CTRL) & io_write_data[CTRL_CLR_BIT];
  assign w_ovf_w1c   = (w_wr && w_reg == REG_OVF_STAT) ? io_write_data[NUM_COUNTERS-1:0] : '0;

  for (genvar g = 0; g < NUM_COUNTERS; g++) begin : g_ctr
    logic w_sel_this;
    assign w_sel_this = (w_cidx == PMU_CIDX_W'(g));

    pmu_counter #(
      .NUM_EVENTS    (NUM_EVENTS),
      .COUNTER_WIDTH (COUNTER_WIDTH)
    ) u_ctr (
      .clk         (clk),
      .reset_n     (reset_n),
      .i_events    (perf_events),
      .i_global_en (r_ctrl_en),
      .i_clear     (w_clear_all),
      .i_load_sel  (w_wr & w_sel_this & (w_reg == REG_SEL)),
      .i_load_lo   (w_wr & w_sel_this & (w_reg == REG_LO)),
      .i_load_hi   (w_wr & w_sel_this & (w_reg == REG_HI)),
      .i_latch_hi  (io_read_en & w_in_win & w_sel_this & (w_reg == REG_LO)),
      .i_wdata     (io_write_data),
      .o_count     (w_count[g]),
      .o_sel       (w_sel[g]),
      .o_hi_hold   (w_hi_hold[g]),
      .o_wrap      (w_wrap[g])
    );
  end

  // CTRL enable, overflow mask and status; a hardware wrap beats a same-cycle W1C
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_ctrl_en  <= 1'b0;
      r_ovf_stat <= '0;
      r_ovf_mask <= '0;
    end else begin
      if (w_wr && w_reg == REG_CTRL)     r_ctrl_en  <= io_write_data[CTRL_EN_BIT];
      if (w_wr && w_reg == REG_OVF_MASK) r_ovf_mask <= io_write_data[NUM_COUNTERS-1:0];
      r_ovf_stat <= (r_ovf_stat & ~w_ovf_w1c) | w_wrap;
    end
  end

  // Read mux over current (pre-edge) state, so a same-cycle write is not visible
  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_CTRL:     w_rdata[CTRL_EN_BIT] = r_ctrl_en;
      REG_OVF_STAT: w_rdata = 32'(r_ovf_stat);
      REG_OVF_MASK: w_rdata = 32'(r_ovf_mask);
      REG_SEL, REG_LO, REG_HI: begin
        for (int i = 0; i < NUM_COUNTERS; i++) begin
          if (w_cidx == PMU_CIDX_W'(i)) begin
            if (w_reg == REG_SEL)     w_rdata = sel_to_word(w_sel[i]);
            else if (w_reg == REG_LO) w_rdata = w_count[i][31:0];
            else                      w_rdata = w_hi_hold[i];
          end
        end
      end
      default: w_rdata = '0;
    endcase
  end

  // Registered read port: hit and data one cycle after io_read_en
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_rhit  <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rhit  <= io_read_en & w_in_win;
      r_rdata <= (io_read_en && w_in_win) ? w_rdata : '0;
    end
  end

  assign pmu_read_data = r_rdata;
  assign pmu_read_hit  = r_rhit;
  assign overflow_irq  = |(r_ovf_stat & r_ovf_mask);

endmodule

// File: tb/tb_perf_monitor_unit.sv
// Directed bench for perf_monitor_unit (8 counters, 16 events, 48-bit counters).
// All bus tasks start and end at a falling edge; the DUT samples on the rising edge between.
module tb_perf_monitor_unit;

  localparam logic [31:0] BASE = 32'hffff1000;

  logic        clk;
  logic        reset_n;
  logic [15:0] perf_events;
  logic        io_write_en;
  logic        io_read_en;
  logic [31:0] io_address;
  logic [31:0] io_write_data;
  logic [31:0] pmu_read_data;
  logic        pmu_read_hit;
  logic        overflow_irq;

  int n_cmp;
  int n_bad;

  perf_monitor_unit #(
    .NUM_COUNTERS  (8),
    .NUM_EVENTS    (16),
    .COUNTER_WIDTH (48),
    .BASE_ADDRESS  (BASE)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .perf_events   (perf_events),
    .io_write_en   (io_write_en),
    .io_read_en    (io_read_en),
    .io_address    (io_address),
    .io_write_data (io_write_data),
    .pmu_read_data (pmu_read_data),
    .pmu_read_hit  (pmu_read_hit),
    .overflow_irq  (overflow_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] a_sel(input int i);
    return BASE + 32'h100 + 32'(16 * i);
  endfunction
  function automatic logic [31:0] a_lo(input int i);
    return BASE + 32'h104 + 32'(16 * i);
  endfunction
  function automatic logic [31:0] a_hi(input int i);
    return BASE + 32'h108 + 32'(16 * i);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_write_en   = 1'b1;
    io_address    = a;
    io_write_data = d;
    @(negedge clk);
    io_write_en   = 1'b0;
    io_write_data = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a,
                        input logic [31:0] exp_d, input logic exp_h);
    io_read_en = 1'b1;
    io_address = a;
    @(negedge clk);
    io_read_en = 1'b0;
    chk({tag, ".data"}, 64'(pmu_read_data), 64'(exp_d));
    chk({tag, ".hit"},  64'(pmu_read_hit),  64'(exp_h));
  endtask

  initial begin
    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    perf_events   = '0;
    io_write_en   = 1'b0;
    io_read_en    = 1'b0;
    io_address    = '0;
    io_write_data = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // 1. reset state
    chk("rst.irq", 64'(overflow_irq), 64'd0);
    chk("rst.hit_idle", 64'(pmu_read_hit), 64'd0);
    rd_chk("rst.ctrl", BASE + 32'h0, 32'h0, 1'b1);
    rd_chk("rst.ovf",  BASE + 32'h4, 32'h0, 1'b1);
    rd_chk("rst.sel0", a_sel(0), 32'h0, 1'b1);
    rd_chk("rst.lo0",  a_lo(0),  32'h0, 1'b1);
    rd_chk("rst.hi0",  a_hi(0),  32'h0, 1'b1);

    // 2. event selection: counter0 on event 3, counter1 on event 2
    wr(a_sel(0), 32'h8000_0003);
    wr(a_sel(1), 32'h8000_0002);
    wr(BASE + 32'h0, 32'h1);
    repeat (10) begin perf_events = 16'h0008; @(negedge clk); end
    repeat (5)  begin perf_events = 16'h0004; @(negedge clk); end
    perf_events = '0;
    rd_chk("cnt.lo0",  a_lo(0), 32'd10, 1'b1);
    rd_chk("cnt.hi0",  a_hi(0), 32'd0,  1'b1);
    rd_chk("cnt.lo1",  a_lo(1), 32'd5,  1'b1);
    rd_chk("cnt.sel0", a_sel(0), 32'h8000_0003, 1'b1);
    rd_chk("cnt.ctrl", BASE + 32'h0, 32'h1, 1'b1);

    // 3. 48-bit wrap, overflow status and masked interrupt
    wr(a_lo(0), 32'hFFFF_FFFF);
    wr(a_hi(0), 32'h0000_FFFF);
    wr(BASE + 32'h8, 32'h1);
    chk("wrap.irq_before", 64'(overflow_irq), 64'd0);
    perf_events = 16'h0008;
    @(negedge clk);
    perf_events = '0;
    chk("wrap.irq_after", 64'(overflow_irq), 64'd1);
    rd_chk("wrap.lo0", a_lo(0), 32'h0, 1'b1);
    rd_chk("wrap.hi0", a_hi(0), 32'h0, 1'b1);
    rd_chk("wrap.ovf", BASE + 32'h4, 32'h1, 1'b1);
    rd_chk("wrap.mask", BASE + 32'h8, 32'h1, 1'b1);
    wr(BASE + 32'h4, 32'h1);
    chk("wrap.irq_w1c", 64'(overflow_irq), 64'd0);
    rd_chk("wrap.ovf_w1c", BASE + 32'h4, 32'h0, 1'b1);

    // 4. coherent read while counting every cycle across the 32-bit boundary
    wr(a_lo(0), 32'hFFFF_FFFF);
    wr(a_hi(0), 32'h0);
    perf_events = 16'h0008;
    rd_chk("coh.lo0", a_lo(0), 32'hFFFF_FFFF, 1'b1);
    repeat (2) @(negedge clk);
    rd_chk("coh.hi0_held", a_hi(0), 32'h0, 1'b1);
    perf_events = '0;
    // four increments landed: 0x0_FFFFFFFF + 4
    rd_chk("coh.lo0_next", a_lo(0), 32'h3, 1'b1);
    rd_chk("coh.hi0_next", a_hi(0), 32'h1, 1'b1);
    rd_chk("coh.ovf", BASE + 32'h4, 32'h0, 1'b1);

    // 5. same-cycle priorities
    perf_events = 16'h0008;
    wr(BASE + 32'h0, 32'h3);
    perf_events = '0;
    rd_chk("pri.clr_lo0", a_lo(0), 32'h0, 1'b1);
    rd_chk("pri.clr_hi0", a_hi(0), 32'h0, 1'b1);
    rd_chk("pri.clr_lo1", a_lo(1), 32'h0, 1'b1);
    rd_chk("pri.ctrl_selfclr", BASE + 32'h0, 32'h1, 1'b1);
    perf_events = 16'h0008;
    wr(a_lo(0), 32'd5);
    perf_events = '0;
    rd_chk("pri.load_lo0", a_lo(0), 32'd5, 1'b1);
    wr(a_lo(0), 32'hFFFF_FFFF);
    wr(a_hi(0), 32'h0000_FFFF);
    perf_events = 16'h0008;
    wr(BASE + 32'h4, 32'h1);
    perf_events = '0;
    chk("pri.irq_set_w1c", 64'(overflow_irq), 64'd1);
    rd_chk("pri.ovf_set_w1c", BASE + 32'h4, 32'h1, 1'b1);
    wr(BASE + 32'h4, 32'h1);
    rd_chk("pri.ovf_clr", BASE + 32'h4, 32'h0, 1'b1);

    // 6. out-of-range event index, SEL bit storage, window edges, reset mid-count
    wr(a_lo(0), 32'h0);
    wr(a_sel(0), 32'h8000_00C8);
    perf_events = 16'hFFFF;
    repeat (5) @(negedge clk);
    perf_events = '0;
    rd_chk("edge.sel0_200", a_sel(0), 32'h8000_00C8, 1'b1);
    rd_chk("edge.lo0_nocount", a_lo(0), 32'h0, 1'b1);
    wr(a_sel(1), 32'hFFFF_FFFF);
    rd_chk("edge.sel1_bits", a_sel(1), 32'h8000_00FF, 1'b1);
    rd_chk("edge.outside", BASE + 32'h2000, 32'h0, 1'b0);
    rd_chk("edge.past_end", BASE + 32'h180, 32'h0, 1'b0);
    rd_chk("edge.below", BASE - 32'h4, 32'h0, 1'b0);
    rd_chk("edge.hole", BASE + 32'hC, 32'h0, 1'b1);
    rd_chk("edge.hole_ctr", BASE + 32'h10C, 32'h0, 1'b1);
    wr(a_sel(7), 32'h8000_0001);
    rd_chk("edge.sel7", a_sel(7), 32'h8000_0001, 1'b1);

    wr(a_sel(0), 32'h8000_0003);
    wr(a_lo(2), 32'h1234_5678);
    perf_events = 16'h0008;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    perf_events = '0;
    chk("rstmid.irq", 64'(overflow_irq), 64'd0);
    chk("rstmid.hit", 64'(pmu_read_hit), 64'd0);
    rd_chk("rstmid.lo0", a_lo(0), 32'h0, 1'b1);
    rd_chk("rstmid.lo2", a_lo(2), 32'h0, 1'b1);
    rd_chk("rstmid.sel0", a_sel(0), 32'h0, 1'b1);
    rd_chk("rstmid.ctrl", BASE + 32'h0, 32'h0, 1'b1);
    rd_chk("rstmid.mask", BASE + 32'h8, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
